// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// fills the IF/ID pipeline register {instruction, pc+4, valid} for ID.
// A one-entry skid buffer absorbs a response that lands during a hazard freeze.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   hazard            freeze IF/ID and PC
//   branch_taken      flush IF/ID and redirect PC to branch_addr (word aligned)
//   imem_req/addr     fetch request; addr is held until imem_ack
//   imem_rdata/ack    fetch response, ack is a one-cycle pulse
//   pc/instruction/valid   IF/ID register outputs
//
// Optional: define IF_PERF_CNT_EN to add fetch_count / stall_count outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] buf_inst, buf_inst_n;
  logic [XLEN-1:0] buf_pc, buf_pc_n;
  logic [XLEN-1:0] pc_n, instruction_n, imem_addr_n;
  logic            valid_n, imem_req_n;
  logic [XLEN-1:0] pc_plus4;
  logic            load_valid;

  assign pc_plus4 = fetch_pc + XLEN'(4);

  // Next-state, PC, buffer and IF/ID update
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    buf_inst_n    = buf_inst;
    buf_pc_n      = buf_pc;
    pc_n          = pc;
    instruction_n = instruction;
    valid_n       = valid;
    load_valid    = 1'b0;

    if (branch_taken) begin
      // Flush beats hazard and ack; an unacked request must still complete, so go via DROP
      pc_n          = '0;
      instruction_n = NOP_INST;
      valid_n       = 1'b0;
      fetch_pc_n    = {branch_addr[XLEN-1:2], 2'b00};
      case (state)
        S_FETCH: state_n = imem_ack ? S_FETCH : S_DROP;
        S_HOLD:  state_n = S_FETCH;
        S_DROP:  state_n = imem_ack ? S_FETCH : S_DROP;
        default: state_n = S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            fetch_pc_n = pc_plus4;
            if (hazard) begin
              buf_inst_n = imem_rdata;
              buf_pc_n   = pc_plus4;
              state_n    = S_HOLD;
            end else begin
              instruction_n = imem_rdata;
              pc_n          = pc_plus4;
              valid_n       = 1'b1;
              load_valid    = 1'b1;
            end
          end else if (!hazard) begin
            // Bubble: ID consumed the previous entry and nothing new arrived
            instruction_n = NOP_INST;
            valid_n       = 1'b0;
          end
        end
        S_HOLD: begin
          if (!hazard) begin
            instruction_n = buf_inst;
            pc_n          = buf_pc;
            valid_n       = 1'b1;
            load_valid    = 1'b1;
            state_n       = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ack) state_n = S_FETCH;
          if (!hazard) begin
            instruction_n = NOP_INST;
            valid_n       = 1'b0;
          end
        end
        default: state_n = S_FETCH;
      endcase
    end

    // DROP keeps presenting the stale address until its ack retires it
    imem_req_n  = (state_n != S_HOLD);
    imem_addr_n = (state_n == S_DROP) ? imem_addr : fetch_pc_n;
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      fetch_pc    <= RESET_PC;
      buf_inst    <= NOP_INST;
      buf_pc      <= '0;
      pc          <= '0;
      instruction <= NOP_INST;
      valid       <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      buf_inst    <= buf_inst_n;
      buf_pc      <= buf_pc_n;
      pc          <= pc_n;
      instruction <= instruction_n;
      valid       <= valid_n;
      imem_req    <= imem_req_n;
      imem_addr   <= imem_addr_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load_valid) fetch_count <= fetch_count + XLEN'(1);
      if (hazard)     stall_count <= stall_count + XLEN'(1);
    end
  end
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, slow ack, hazard skid,
// branch during outstanding fetch, branch+hazard, PC wrap and async reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  // Memory model: auto mode acks every request in the same cycle with addr>>2
  logic        auto_mode;
  logic        man_ack;
  logic [31:0] man_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    imem_ack   = auto_mode ? imem_req : man_ack;
    imem_rdata = auto_mode ? (imem_addr >> 2) : man_rdata;
  end

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .pc           (pc),
    .instruction  (instruction),
    .valid        (valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; hazard = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    auto_mode = 1'b1; man_ack = 1'b0; man_rdata = '0;

    // Reset state
    step(); step();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_inst",  instruction, NOP);
    chk("rst_valid", 32'(valid), 32'd0);
    rst = 1'b1;

    // 1: streaming at one instruction per cycle
    step();
    chk("t1_req",    32'(imem_req), 32'd1);
    chk("t1_addr0",  imem_addr, 32'h0);
    chk("t1_valid0", 32'(valid), 32'd0);
    step();
    chk("t1_pc4",    pc, 32'h4);
    chk("t1_inst0",  instruction, 32'h0);
    chk("t1_valid1", 32'(valid), 32'd1);
    chk("t1_addr4",  imem_addr, 32'h4);
    step();
    chk("t1_pc8",    pc, 32'h8);
    chk("t1_inst1",  instruction, 32'h1);
    chk("t1_addr8",  imem_addr, 32'h8);
    step();
    chk("t1_pc12",   pc, 32'hC);
    chk("t1_inst2",  instruction, 32'h2);
    chk("t1_valid3", 32'(valid), 32'd1);

    // 2: ack three cycles after request, async reset clears IF/ID first
    auto_mode = 1'b0; man_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("t2_async_valid", 32'(valid), 32'd0);
    chk("t2_async_pc",    pc, 32'h0);
    rst = 1'b1;
    step();
    chk("t2_addr_c1", imem_addr, 32'h0);
    chk("t2_req_c1",  32'(imem_req), 32'd1);
    step();
    chk("t2_addr_c2", imem_addr, 32'h0);
    step();
    chk("t2_addr_c3", imem_addr, 32'h0);
    chk("t2_valid_w", 32'(valid), 32'd0);
    man_ack = 1'b1; man_rdata = 32'hE281_1001;
    step();
    chk("t2_pc",    pc, 32'h4);
    chk("t2_inst",  instruction, 32'hE281_1001);
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_addr",  imem_addr, 32'h4);

    // 3: hazard while a response arrives -> skid buffer
    hazard = 1'b1; man_ack = 1'b1; man_rdata = 32'hE3A0_0014;
    step();
    chk("t3_req_h0",  32'(imem_req), 32'd0);
    chk("t3_inst_h0", instruction, 32'hE281_1001);
    chk("t3_pc_h0",   pc, 32'h4);
    chk("t3_val_h0",  32'(valid), 32'd1);
    man_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_h",  32'(imem_req), 32'd0);
      chk("t3_inst_h", instruction, 32'hE281_1001);
    end
    hazard = 1'b0;
    step();
    chk("t3_inst", instruction, 32'hE3A0_0014);
    chk("t3_pc",   pc, 32'h8);
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_req",  32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h8);
    step();
    chk("t3_bubble_valid", 32'(valid), 32'd0);
    chk("t3_bubble_inst",  instruction, NOP);
    chk("t3_bubble_addr",  imem_addr, 32'h8);

    // 4: branch during outstanding fetch of 0x8
    branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    chk("t4_valid", 32'(valid), 32'd0);
    chk("t4_req",   32'(imem_req), 32'd1);
    chk("t4_addr",  imem_addr, 32'h8);
    branch_taken = 1'b0;
    step();
    chk("t4_addr_hold", imem_addr, 32'h8);
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    step();
    chk("t4_addr_new",  imem_addr, 32'h100);
    chk("t4_drop_valid", 32'(valid), 32'd0);
    chk("t4_drop_inst",  instruction, NOP);
    man_rdata = 32'hE3A0_1002;
    step();
    chk("t4_pc",    pc, 32'h104);
    chk("t4_inst",  instruction, 32'hE3A0_1002);
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_addr2", imem_addr, 32'h104);
    man_ack = 1'b0;

    // 5: branch and hazard together, flush wins; low address bits ignored
    hazard = 1'b1; branch_taken = 1'b1; branch_addr = 32'h203;
    step();
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_inst",  instruction, NOP);
    chk("t5_pc",    pc, 32'h0);
    chk("t5_addr_old", imem_addr, 32'h104);
    hazard = 1'b0; branch_taken = 1'b0; man_ack = 1'b1;
    step();
    chk("t5_addr", imem_addr, 32'h200);
    chk("t5_req",  32'(imem_req), 32'd1);

    // 6: PC wrap, then async reset mid-wait
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF; man_ack = 1'b1;
    step();
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t6_valid0",   32'(valid), 32'd0);
    branch_taken = 1'b0; man_rdata = 32'h1122_3344;
    step();
    chk("t6_pc_wrap", pc, 32'h0);
    chk("t6_inst",    instruction, 32'h1122_3344);
    chk("t6_addr0",   imem_addr, 32'h0);
    man_rdata = 32'h5566_7788;
    step();
    chk("t6_pc4", pc, 32'h4);
    man_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_pc",    pc, 32'h0);
    chk("t6_rst_inst",  instruction, NOP);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_req",   32'(imem_req), 32'd0);
    chk("t6_rst_addr",  imem_addr, 32'h0);
    rst = 1'b1;
    step();
    chk("t6_req_after", 32'(imem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM968E-S core, directly upstream of the ID stage.
- Holds the PC and fetches from the instruction memory over a req/ack handshake.
- Registers {instruction, pc+4, valid} into the IF/ID pipeline register consumed by the ID stage.
- Honours hazard freeze from the hazard unit and branch redirect/flush from EXE.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INST, 32'hE1A0_0000, instruction driven to ID when the IF/ID register is empty or flushed (MOV R0,R0)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
hazard  in  1  freeze request from hazard unit; 1 = hold IF/ID and PC
branch_taken  in  1  redirect/flush request from EXE
branch_addr  in  32  redirect target, word-aligned
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; equals the PC, stable while imem_req=1 and no ack
imem_rdata  in  32  fetched word; valid when imem_ack=1
imem_ack  in  1  one-cycle completion pulse for the outstanding request
pc  out  32  IF/ID register: address of the fetched instruction + 4
instruction  out  32  IF/ID register: fetched instruction
valid  out  1  IF/ID register holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC, state=FETCH, pc=0, instruction=NOP_INST, valid=0, buffer empty.
  - imem_req=0 while rst=0; imem_req=1 from the first edge after release.
- States:
  - FETCH: imem_req=1, imem_addr=PC.
  - HOLD: imem_req=0; a fetched word waits in the skid buffer.
  - DROP: imem_req=1, imem_addr=old PC; response will be discarded.
- Request rule: once imem_req=1, imem_addr stays constant until the cycle imem_ack=1. A request is never withdrawn early.
- FETCH, imem_ack=1, hazard=0, branch_taken=0:
  - IF/ID <= {imem_rdata, PC+4, 1}; PC <= PC+4; stay in FETCH.
  - Back-to-back acks sustain 1 instruction/cycle when memory acks combinationally.
- FETCH, imem_ack=1, hazard=1:
  - Buffer <= {imem_rdata, PC+4}; PC <= PC+4; go to HOLD.
  - IF/ID holds its current contents.
- HOLD, hazard=0: IF/ID <= buffer, valid=1; go to FETCH.
- HOLD, hazard=1: everything holds.
- branch_taken=1 (priority over hazard and ack):
  - IF/ID <= {NOP_INST, 0, 0}; buffer discarded; PC <= branch_addr.
  - FETCH with imem_ack=1 this cycle: data dropped; stay in FETCH at the new PC next cycle.
  - FETCH with no ack: go to DROP.
  - HOLD: go to FETCH.
  - DROP: only the PC is updated; stay in DROP.
- DROP, imem_ack=1: response discarded; go to FETCH. A branch in the same cycle updates the PC.
- hazard=1 with IF/ID empty: still a freeze; the PC does not advance beyond one buffered word.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). branch_addr[1:0] is ignored (forced to 0).
- Reset asserted mid-request: all state clears immediately. Any later stray imem_ack while in FETCH at RESET_PC is treated as a valid response; memory must not ack across reset.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every IF/ID load with valid=1.
  - stall_count increments every cycle with hazard=1 and rst=1.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, RESET_PC=0, memory acks same cycle with word at addr>>2 -> imem_addr 0,4,8 on successive cycles; pc outputs 4,8,12, valid=1 each cycle after the first ack.
2. Ack 3 cycles after req -> imem_addr holds 0x0 for 3 cycles; pc=4 appears on the edge after the ack; valid=1 for exactly one load.
3. hazard=1 for 4 cycles while an ack of 32'hE3A00014 arrives -> IF/ID unchanged, imem_req=0 in HOLD; after hazard=0, instruction=32'hE3A00014, pc=PC+4 next edge.
4. branch_taken=1, branch_addr=0x100 during an outstanding fetch of 0x8 (no ack yet) -> valid=0 next cycle, req stays on 0x8 until ack; ack data discarded; next imem_addr=0x100, then pc=0x104.
5. branch_taken and hazard both 1 in the same cycle -> flush wins: valid=0, instruction=NOP_INST, PC=branch_addr.
6. PC at 32'hFFFF_FFFC fetched -> pc output 0, next imem_addr 0; rst pulsed low mid-wait -> outputs return to reset values immediately, asynchronously.
